scratchmem_arb: RTL and testbench
=================================

# scratchmem_arb

Two-master arbiter and sequencer for the 128-bit on-chip scratchpad memory. It accepts independent bus requests from an instruction-fetch master (m0) and a load/store master (m1). It grants the single scratchpad slave port to one master at a time with round-robin fairness and returns the read data and acknowledge to the winner. It also enforces the slave's recovery rule: chip select drops after every acknowledge, and the slave's ack must return low before the next grant. A per-transaction timeout converts a missing acknowledge into a bus error.

## Interface
Parameters:
- TIMEOUT, 64, cycles in ACTIVE without s_ack_i before the transaction is aborted with an error (legal range 4..255).

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 bus cycle, strobe and write enable.
- m0_sel_i  input  16  master 0 byte lane selects.
- m0_adr_i  input  18  master 0 byte address.
- m0_dat_i  input  128  master 0 write data.
- m0_ack_o, m0_err_o  output  1 each  master 0 acknowledge and error; each is a one-cycle pulse.
- m0_dat_o  output  128  master 0 read data; valid while m0_ack_o is high.
- m1_*  same set as m0_*  master 1.
- s_cs_o, s_cyc_o, s_stb_o, s_we_o  output  1 each  slave select, cycle, strobe and write enable.
- s_sel_o  output  16  slave byte lane selects.
- s_adr_o  output  18  slave byte address.
- s_dat_o  output  128  slave write data.
- s_bndx_o  output  8  transaction tag; {7'd0, grant id}.
- s_ack_i  input  1  slave acknowledge; level, held while the slave select stays asserted.
- s_dat_i  input  128  slave read data; valid with s_ack_i.
- s_bndx_i  input  8  tag returned by the slave; checked by the bench only.

## Operation
- State machine: IDLE, ACTIVE, RECOVER.
- A master is requesting when its cyc_i & stb_i are both high.
- IDLE:
  - With no requester, stay in IDLE.
  - With one requester, grant it.
  - With both requesting, grant the master not served last. The last-served register resets to 1, so m0 wins the first contention.
  - On grant:
    - latch that master's we, sel, adr and dat into the slave-side registers;
    - set gnt to the master id;
    - clear the timeout counter;
    - go to ACTIVE.
- ACTIVE:
  - s_cs_o = s_cyc_o = s_stb_o = 1, with the latched fields driven.
  - Master-side inputs are ignored after the latch.
  - On s_ack_i = 1:
    - pulse ack_o of the granted master for one cycle;
    - for reads, register s_dat_i into that master's dat_o;
    - update last-served to gnt;
    - deassert all slave strobes;
    - go to RECOVER.
  - If the counter reaches TIMEOUT-1 with s_ack_i = 0:
    - pulse err_o of the granted master instead of ack_o;
    - leave dat_o unchanged;
    - update last-served;
    - go to RECOVER.
  - Otherwise the counter increments by 1; it is 8 bits wide and saturates.
- RECOVER:
  - Slave strobes stay low.
  - Remain in RECOVER while s_ack_i = 1, so the slave's delayed-ack pipeline drains.
  - Exit to IDLE on the first cycle with s_ack_i = 0. The minimum stay is 1 cycle.
- Masters must drop stb_i in the cycle after they receive ack_o or err_o. Because RECOVER lasts at least 1 cycle, a master that follows this rule is never regranted on a stale strobe.
- A master that drops cyc_i while it holds the grant does not abort the transaction. The transaction completes, and the ack_o/err_o pulse is still issued.
- m0_dat_o and m1_dat_o hold their last read value and are not zeroed between transactions.

## Timing
- Reset values:
  - state IDLE, gnt 0, last-served 1, counter 0;
  - every output 0, including both dat_o buses and s_bndx_o.
- Reset mid-transaction: on the reset cycle the slave strobes drop, and no ack_o or err_o is issued.
- Grant latency: request sampled in IDLE at cycle N; slave strobes high from N+1.
- Slave contract: a read acks 3 cycles after strobes rise (s_ack_i high at N+4); a write acks 1 cycle after (N+2).
- Master-side response, registered:
  - read: ack_o and dat_o at N+5;
  - write: ack_o at N+3.
- Recovery and back-to-back throughput:
  - RECOVER is entered at N+5 (read) or N+3 (write), in the same cycle as the master ack_o pulse.
  - s_ack_i falls 1 cycle after the strobes drop, so RECOVER lasts 1 cycle.
  - IDLE can grant the next request 1 cycle after RECOVER. Back-to-back reads therefore issue every 6 cycles.
- Timeout: with the strobes rising at N+1 and no s_ack_i, err_o pulses at N+1+TIMEOUT.
- Simultaneous s_ack_i and timeout in the same cycle: the ack wins.

## Test plan
- Single read: m1 reads 0x00120 with the slave returning 128'hDEAD..BEEF → s_adr_o=0x00120, s_bndx_o=8'h01, m1_ack_o pulses once at N+5 with m1_dat_o=DEAD..BEEF, m0_ack_o stays 0.
- Contention: m0 and m1 both request continuously out of reset → grant order m0, m1, m0, m1 across 4 transactions, with exactly one ack_o per transaction and s_cs_o low for ≥1 cycle between transactions.
- Write sequencing: m0 writes sel=16'h00F0, dat=128'h1234 to 0x00040 → slave sees we=1 and sel=00F0 from N+1; m0_ack_o at N+3; the slave's read back of 0x00040 returns the written bytes in lanes 4-7.
- Timeout: TIMEOUT=8, slave never acks → m0_err_o pulses once at N+9, m0_ack_o stays 0, and a subsequent m1 request is granted 2 cycles after the err_o pulse.
- Stuck ack in RECOVER: the slave holds s_ack_i high 4 extra cycles after the strobes drop → the FSM stays in RECOVER, no new grant is issued, and a pending m1 request is granted the cycle after s_ack_i falls.
- Reset mid-read: assert rst_i at N+3 of an m0 read → all outputs 0 on the next cycle, no m0_ack_o, and the next contention grants m0 first.

Source files
------------

// File: rtl/scratchmem_arb.sv
// scratchmem_arb: round-robin arbiter between an instruction-fetch and a load/store master
// for the 128-bit scratchpad port, with post-ack recovery and a per-transaction timeout.
module scratchmem_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         m0_cyc_i,
  input  logic         m0_stb_i,
  input  logic         m0_we_i,
  input  logic [15:0]  m0_sel_i,
  input  logic [17:0]  m0_adr_i,
  input  logic [127:0] m0_dat_i,
  output logic         m0_ack_o,
  output logic         m0_err_o,
  output logic [127:0] m0_dat_o,
  input  logic         m1_cyc_i,
  input  logic         m1_stb_i,
  input  logic         m1_we_i,
  input  logic [15:0]  m1_sel_i,
  input  logic [17:0]  m1_adr_i,
  input  logic [127:0] m1_dat_i,
  output logic         m1_ack_o,
  output logic         m1_err_o,
  output logic [127:0] m1_dat_o,
  output logic         s_cs_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [15:0]  s_sel_o,
  output logic [17:0]  s_adr_o,
  output logic [127:0] s_dat_o,
  output logic [7:0]   s_bndx_o,
  input  logic         s_ack_i,
  input  logic [127:0] s_dat_i,
  input  logic [7:0]   s_bndx_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           act_q, act_d;
  logic           we_q, we_d;
  logic [15:0]    sel_q, sel_d;
  logic [17:0]    adr_q, adr_d;
  logic [127:0]   wdat_q, wdat_d;
  logic           m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic           m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [127:0]   m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;
  logic           req0_s, req1_s, pick_s;
  logic           unused_s;

  // Contention goes to the master that was not served last.
  function automatic logic pick_master(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end else if (r1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

  assign req0_s   = m0_cyc_i & m0_stb_i;
  assign req1_s   = m1_cyc_i & m1_stb_i;
  assign pick_s   = pick_master(req0_s, req1_s, last_q);
  assign unused_s = ^s_bndx_i;

  // Next-state, latch and response computation.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    m0_ack_d = 1'b0;
    m0_err_d = 1'b0;
    m1_ack_d = 1'b0;
    m1_err_d = 1'b0;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    case (state_q)
      IDLE: begin
        if (req0_s || req1_s) begin
          gnt_d   = pick_s;
          we_d    = pick_s ? m1_we_i  : m0_we_i;
          sel_d   = pick_s ? m1_sel_i : m0_sel_i;
          adr_d   = pick_s ? m1_adr_i : m0_adr_i;
          wdat_d  = pick_s ? m1_dat_i : m0_dat_i;
          cnt_d   = 8'd0;
          act_d   = 1'b1;
          state_d = ACTIVE;
        end else begin
          act_d   = 1'b0;
        end
      end
      ACTIVE: begin
        // The ack is tested before the timeout so a coincident ack wins.
        if (s_ack_i) begin
          if (gnt_q) begin
            m1_ack_d = 1'b1;
            m1_dat_d = we_q ? m1_dat_q : s_dat_i;
          end else begin
            m0_ack_d = 1'b1;
            m0_dat_d = we_q ? m0_dat_q : s_dat_i;
          end
          last_d  = gnt_q;
          act_d   = 1'b0;
          state_d = RECOVER;
        end else if (cnt_q == CNT_LAST) begin
          if (gnt_q) begin
            m1_err_d = 1'b1;
          end else begin
            m0_err_d = 1'b1;
          end
          last_d  = gnt_q;
          act_d   = 1'b0;
          state_d = RECOVER;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RECOVER: begin
        act_d = 1'b0;
        if (!s_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
        end
      end
      default: begin
        act_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset also drops the strobes of an in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 8'd0;
      act_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 16'd0;
      adr_q    <= 18'd0;
      wdat_q   <= 128'd0;
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;
      m0_dat_q <= 128'd0;
      m1_dat_q <= 128'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      m0_ack_q <= m0_ack_d;
      m0_err_q <= m0_err_d;
      m1_ack_q <= m1_ack_d;
      m1_err_q <= m1_err_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  end

  assign s_cs_o   = act_q;
  assign s_cyc_o  = act_q;
  assign s_stb_o  = act_q;
  assign s_we_o   = we_q;
  assign s_sel_o  = sel_q;
  assign s_adr_o  = adr_q;
  assign s_dat_o  = wdat_q;
  assign s_bndx_o = {7'd0, gnt_q};
  assign m0_ack_o = m0_ack_q;
  assign m0_err_o = m0_err_q;
  assign m0_dat_o = m0_dat_q;
  assign m1_ack_o = m1_ack_q;
  assign m1_err_o = m1_err_q;
  assign m1_dat_o = m1_dat_q;

endmodule

// File: tb/tb_scratchmem_arb.sv
// Directed bench for scratchmem_arb: a behavioural scratchpad slave plus a scoreboard of
// expected master responses, popped whenever an ack_o/err_o pulse appears.
module tb_scratchmem_arb;
  localparam int TIMEOUT = 8;
  localparam logic [127:0] DB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  logic clk_i = 1'b0;
  logic rst_i;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [15:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [17:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [127:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cs_o, s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [7:0] s_bndx_o;
  logic [7:0] s_bndx_i = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  scratchmem_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cs_o(s_cs_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_bndx_o(s_bndx_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .s_bndx_i(s_bndx_i)
  );

  function automatic logic [127:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i), 32'h12340000 + 32'(i), 32'h0F0F0000 + 32'(i)};
  endfunction

  // Slave: reads ack 3 cycles after the strobes rise, writes 1 cycle after; ack is held
  // while selected, optionally stretched, or suppressed entirely.
  logic [127:0] mem [0:255];
  logic [7:0] scnt_q = 8'd0;
  logic [3:0] hold_q = 4'd0;
  logic [3:0] stuck_extra = 4'd0;
  logic never_ack = 1'b0;
  logic ack_now;

  assign ack_now = s_cs_o && !never_ack && (scnt_q >= (s_we_o ? 8'd1 : 8'd3));
  assign s_ack_i = ack_now || (hold_q != 4'd0);
  assign s_dat_i = mem[s_adr_o[11:4]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    mem[8'h12] = DB;
  end

  always @(posedge clk_i) begin
    scnt_q   <= s_cs_o ? scnt_q + 8'd1 : 8'd0;
    s_bndx_i <= s_bndx_o;
    if (ack_now) begin
      hold_q <= stuck_extra;
      if (s_we_o) begin
        for (int b = 0; b < 16; b++)
          if (s_sel_o[b]) mem[s_adr_o[11:4]][8*b +: 8] <= s_dat_o[8*b +: 8];
      end
    end else if (hold_q != 4'd0) begin
      hold_q <= hold_q - 4'd1;
    end
  end

  typedef struct {
    logic mid;
    logic err;
    logic [127:0] dat;
  } exp_t;
  exp_t sb_q[$];
  exp_t e_m;
  logic [3:0] flags_m;
  logic [3:0] eflags_m;

  // Every response pulse must match the oldest expected response.
  always @(negedge clk_i) begin
    flags_m = {m1_err_o, m1_ack_o, m0_err_o, m0_ack_o};
    if (flags_m != 4'd0) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_bad++;
        $error("FAIL sb_unexpected: observed flags %b expected no response", flags_m);
      end
      if (sb_q.size() != 0) begin
        e_m = sb_q.pop_front();
        eflags_m = 4'b0001 << {e_m.mid, e_m.err};
        n_cmp++;
        assert ({flags_m, (e_m.mid ? m1_dat_o : m0_dat_o)} === {eflags_m, e_m.dat}) else begin
          n_bad++;
          $error("FAIL sb_resp: observed %b/%h expected %b/%h", flags_m,
                 (e_m.mid ? m1_dat_o : m0_dat_o), eflags_m, e_m.dat);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic req(input int m, input logic we, input logic [15:0] sel,
                     input logic [17:0] adr, input logic [127:0] dat);
    if (m == 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    end else begin
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    end
  endtask

  task automatic push(input logic mid, input logic err, input logic [127:0] dat);
    exp_t e;
    e.mid = mid; e.err = err; e.dat = dat;
    sb_q.push_back(e);
  endtask

  logic [127:0] mask;
  int gap;

  initial begin
    rst_i = 1'b1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 16'd0; m0_adr_i = 18'd0; m0_dat_i = 128'd0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 16'd0; m1_adr_i = 18'd0; m1_dat_i = 128'd0;
    step(3);
    chk("rst_ctl", 128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cs_o, s_cyc_o, s_stb_o, s_we_o,
                         s_sel_o, s_adr_o, s_bndx_o}), 128'd0);
    chk("rst_m0_dat", m0_dat_o, 128'd0);
    chk("rst_m1_dat", m1_dat_o, 128'd0);
    chk("rst_s_dat", s_dat_o, 128'd0);
    rst_i = 1'b0;

    // Contention out of reset: m0, m1, m0, m1.
    push(1'b0, 1'b0, pat(8'h20)); push(1'b1, 1'b0, pat(8'h30));
    push(1'b0, 1'b0, pat(8'h20)); push(1'b1, 1'b0, pat(8'h30));
    req(0, 1'b0, 16'hFFFF, 18'h00200, 128'd0);
    req(1, 1'b0, 16'hFFFF, 18'h00300, 128'd0);
    for (int t = 0; t < 4; t++) begin
      gap = 0;
      for (int k = 0; k < 20 && !s_cs_o; k++) begin gap++; step(1); end
      chk("cont_cs_rise", 128'(s_cs_o), 128'd1);
      chk("cont_gnt", 128'(s_bndx_o), 128'(t % 2));
      if (t > 0) chk("cont_gap", 128'(gap >= 1), 128'd1);
      if (t == 3) begin drop(0); drop(1); end
      for (int k = 0; k < 20 && s_cs_o; k++) step(1);
    end
    step(2);
    chk("cont_drain", 128'(sb_q.size()), 128'd0);

    // Single m1 read.
    push(1'b1, 1'b0, DB);
    req(1, 1'b0, 16'hFFFF, 18'h00120, 128'd0);
    step(1);
    chk("rd_cs", 128'({s_cs_o, s_cyc_o, s_stb_o, s_we_o}), 128'hE);
    chk("rd_adr", 128'(s_adr_o), 128'h120);
    chk("rd_bndx", 128'(s_bndx_o), 128'h01);
    drop(1);
    step(3);
    chk("rd_ack_early", 128'({m0_ack_o, m1_ack_o}), 128'd0);
    step(1);
    chk("rd_ack", 128'({m0_ack_o, m1_ack_o}), 128'b01);
    chk("rd_dat", m1_dat_o, DB);
    step(1);
    chk("rd_ack_pulse", 128'(m1_ack_o), 128'd0);

    // Timeout on m0 followed by a pending m1 read.
    never_ack = 1'b1;
    push(1'b0, 1'b1, pat(8'h20));
    req(0, 1'b0, 16'hFFFF, 18'h00080, 128'd0);
    step(1);
    drop(0);
    push(1'b1, 1'b0, pat(8'h30));
    req(1, 1'b0, 16'hFFFF, 18'h00300, 128'd0);
    step(7);
    chk("to_err_early", 128'({m0_err_o, s_cs_o}), 128'b01);
    step(1);
    chk("to_err", 128'({m0_err_o, m0_ack_o, s_cs_o}), 128'b100);
    never_ack = 1'b0;
    step(1);
    chk("to_gap", 128'({m0_err_o, s_cs_o}), 128'd0);
    step(1);
    chk("to_next_gnt", 128'({s_cs_o, s_bndx_o}), 128'h101);
    drop(1);
    step(4);
    chk("to_m1_ack", 128'(m1_ack_o), 128'd1);
    step(1);

    // Stuck ack in RECOVER blocks the pending m1 request.
    stuck_extra = 4'd4;
    push(1'b0, 1'b0, pat(8'h21));
    req(0, 1'b0, 16'hFFFF, 18'h00210, 128'd0);
    step(1);
    drop(0);
    push(1'b1, 1'b0, pat(8'h31));
    req(1, 1'b0, 16'hFFFF, 18'h00310, 128'd0);
    step(4);
    chk("st_ack", 128'({m0_ack_o, s_cs_o, s_ack_i}), 128'b101);
    stuck_extra = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("st_hold", 128'({s_cs_o, s_ack_i}), 128'b01);
    end
    step(1);
    chk("st_fall", 128'({s_cs_o, s_ack_i}), 128'b00);
    step(1);
    chk("st_idle", 128'(s_cs_o), 128'd0);
    step(1);
    chk("st_gnt", 128'({s_cs_o, s_bndx_o}), 128'h101);
    drop(1);
    step(4);
    chk("st_m1_ack", 128'(m1_ack_o), 128'd1);
    step(1);

    // m0 partial write and read-back.
    push(1'b0, 1'b0, pat(8'h21));
    req(0, 1'b1, 16'h00F0, 18'h00040, 128'h1234);
    step(1);
    chk("wr_slave", 128'({s_cs_o, s_we_o, s_sel_o, s_adr_o}), 128'({1'b1, 1'b1, 16'h00F0, 18'h00040}));
    chk("wr_sdat", s_dat_o, 128'h1234);
    drop(0);
    step(1);
    chk("wr_ack_early", 128'(m0_ack_o), 128'd0);
    step(1);
    chk("wr_ack", 128'(m0_ack_o), 128'd1);
    chk("wr_m1_hold", m1_dat_o, pat(8'h31));
    step(1);
    for (int b = 0; b < 16; b++) mask[8*b +: 8] = (b >= 4 && b <= 7) ? 8'hFF : 8'h00;
    push(1'b0, 1'b0, (pat(4) & ~mask) | (128'h1234 & mask));
    req(0, 1'b0, 16'hFFFF, 18'h00040, 128'd0);
    step(1);
    drop(0);
    step(4);
    chk("rb_ack", 128'(m0_ack_o), 128'd1);
    step(1);

    // Reset in the middle of an m0 read.
    req(0, 1'b0, 16'hFFFF, 18'h00200, 128'd0);
    step(3);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    drop(0);
    chk("mr_ctl", 128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cs_o, s_cyc_o, s_stb_o, s_we_o,
                        s_sel_o, s_adr_o, s_bndx_o}), 128'd0);
    chk("mr_dat", {m0_dat_o[63:0], m1_dat_o[63:0]}, 128'd0);
    step(3);
    chk("mr_no_ack", 128'(m0_ack_o), 128'd0);
    push(1'b0, 1'b0, pat(8'h22)); push(1'b1, 1'b0, pat(8'h32));
    req(0, 1'b0, 16'hFFFF, 18'h00220, 128'd0);
    req(1, 1'b0, 16'hFFFF, 18'h00320, 128'd0);
    step(1);
    chk("mr_gnt0", 128'({s_cs_o, s_bndx_o}), 128'h100);
    drop(0);
    step(6);
    chk("mr_gnt1", 128'({s_cs_o, s_bndx_o}), 128'h101);
    drop(1);
    step(6);
    chk("final_drain", 128'(sb_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
